fp_div_sequencer: RTL
=====================

FP_DIV_SEQUENCER -- requirements
Module: fp_div_sequencer

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 4, giving the number of cycles the combinational divider inputs are held stable before its quotient is sampled (legal range 1..15).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have ports in_valid (input, 1), in_ready (output, 1), in_a (input, 32), and in_b (input, 32) forming the operand handshake; in_a is the IEEE-754 single-precision dividend and in_b is the divisor.
REQ-005 SHALL have ports div_a (output, 32) and div_b (output, 32), which drive the dividend and divisor of the downstream combinational divider.
REQ-006 SHALL have port div_q (input, 32): the quotient returned by that divider.
REQ-007 SHALL have ports out_valid (output, 1), out_ready (input, 1), and out_q (output, 32) forming the result handshake.
REQ-008 SHALL have port out_flags (output, 3): bit 2 is invalid, bit 1 is divide-by-zero, bit 0 is bypass (the result did not come from the divider).

Function
REQ-009 SHALL implement a three-state FSM: IDLE, SETTLE, HOLD.
REQ-010 SHALL drive in_ready=1 in IDLE only.
REQ-011 SHALL drive in_ready=0 in SETTLE and HOLD, so there is no operand overlap.
REQ-012 SHALL, in IDLE with in_valid=1, register in_a and in_b into the operand register and classify both operands in the same cycle.
REQ-013 SHALL classify each operand as: zero when exp==0 (denormals flushed to zero); inf when exp==8'hFF and mant==0; NaN when exp==8'hFF and mant!=0; normal otherwise.
REQ-014 SHALL produce a bypass result, overriding the divider, for these cases:
  - NaN operand, 0/0, or inf/inf: result 32'h7FC00000, flags 3'b101.
  - Finite nonzero / zero: result {sign,8'hFF,23'h0}, flags 3'b011.
  - inf / finite: result {sign,8'hFF,23'h0}, flags 3'b001.
  - Zero / nonzero, or finite / inf: result {sign,31'h0}, flags 3'b001.
REQ-015 SHALL compute sign as in_a[31]^in_b[31] for all non-NaN results.
REQ-016 SHALL, on accepting a bypass case, go IDLE->HOLD with out_q and out_flags loaded; out_valid is asserted the cycle after acceptance (latency 1).
REQ-017 SHALL, on accepting a normal/normal case, go IDLE->SETTLE and load a 4-bit counter with SETTLE_CYCLES-1.
REQ-018 SHALL, in SETTLE, decrement the counter each cycle.
REQ-019 SHALL, when the counter reaches 0, register div_q into out_q with flags 3'b000 and go to HOLD; out_valid is asserted SETTLE_CYCLES+1 cycles after acceptance.
REQ-020 SHALL drive div_a and div_b from the operand register at all times, so they are stable through SETTLE and HOLD; they change only when a new operand is accepted.
REQ-021 SHALL, in HOLD, keep out_valid=1 with out_q and out_flags stable until out_ready=1, then go HOLD->IDLE and deassert out_valid in the following cycle.
REQ-022 SHALL allow out_ready to be asserted before out_valid; this has no effect outside HOLD.
REQ-023 SHALL ignore in_valid outside IDLE.
REQ-024 SHALL require that in_a and in_b not be sampled in any state other than IDLE.
REQ-025 SHALL accept a new operand pair no earlier than the cycle after the HOLD->IDLE transition, giving a minimum issue interval of SETTLE_CYCLES+3 cycles for normal operands.

Reset
REQ-026 SHALL, with rst_n=0 at a rising clk edge, force: state=IDLE, counter=0, operand register=0 (so div_a=div_b=0), out_q=0, out_flags=0, out_valid=0; in_ready=1 from the first cycle after reset releases.
REQ-027 SHALL, on reset asserted mid-SETTLE or mid-HOLD, discard the in-flight operation; no out_valid pulse follows reset release.

Structure
REQ-028 SHALL place the state enum, QNAN constant 32'h7FC00000, exponent/mantissa field widths and flag bit indices in shared package fp_div_pkg.
REQ-029 SHALL instantiate combinational sub-module fp_classify once per operand; it outputs is_zero, is_inf, is_nan and is_normal.
REQ-030 SHALL NOT instantiate the divider itself; the divider connects externally via div_a, div_b and div_q.

Verification
REQ-031 SHALL verify: 0x40C00000 / 0x40000000 with SETTLE_CYCLES=4 -> out_q within 1 ulp of 0x40400000, flags 3'b000, out_valid 5 cycles after acceptance.
REQ-032 SHALL verify: 0xC1000000 / 0x40000000 -> out_q within 1 ulp of 0xC0800000, flags 3'b000.
REQ-033 SHALL verify: 0x3F800000 / 0x00000000 -> out_q 0x7F800000, flags 3'b011, out_valid 1 cycle after acceptance; 0x80000000 / 0x00000000 -> 0x7FC00000, flags 3'b101.
REQ-034 SHALL verify: out_ready held low 3 cycles in HOLD -> out_q, out_flags and out_valid stable, in_ready=0 throughout; in_valid pulses during that window are not accepted.
REQ-035 SHALL verify: rst_n=0 for one cycle at SETTLE counter=2 -> all outputs at reset values, no out_valid afterwards, and in_ready=1 on the next cycle.
REQ-036 SHALL verify: back-to-back in_valid with out_ready tied high -> accepts spaced exactly SETTLE_CYCLES+3 cycles apart.

Source files
------------

// File: rtl/fp_div_pkg.sv
// Shared types and constants for the single-precision divide sequencer.
// Holds the FSM state encoding, IEEE-754 field layout and result flag bit positions.
package fp_div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    localparam int FP_W    = 32;
    localparam int EXP_W   = 8;
    localparam int MANT_W  = 23;
    localparam int FLAGS_W = 3;
    localparam int CNT_W   = 4;

    localparam logic [FP_W-1:0] QNAN = 32'h7FC0_0000;

    localparam int FLAG_INVALID = 2;
    localparam int FLAG_DIVZ    = 1;
    localparam int FLAG_BYPASS  = 0;

endpackage

// File: rtl/fp_classify.sv
// Combinational IEEE-754 single-precision operand classifier.
// Denormals are flushed to zero, so any operand with a zero exponent reports is_zero.
module fp_classify
    import fp_div_pkg::*;
(
    input  logic [FP_W-1:0] op,
    output logic            is_zero,
    output logic            is_inf,
    output logic            is_nan,
    output logic            is_normal
);

    logic [EXP_W-1:0]  w_exp;
    logic [MANT_W-1:0] w_mant;

    assign w_exp  = op[MANT_W +: EXP_W];
    assign w_mant = op[MANT_W-1:0];

    assign is_zero   = (w_exp == '0);
    assign is_inf    = (w_exp == '1) && (w_mant == '0);
    assign is_nan    = (w_exp == '1) && (w_mant != '0);
    assign is_normal = !is_zero && (w_exp != '1);

endmodule

// File: rtl/fp_div_sequencer.sv
// Sequences one operand pair through an external combinational FP divider,
// resolving special operands locally and waiting SETTLE_CYCLES before sampling the quotient.
module fp_div_sequencer
    import fp_div_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [FP_W-1:0]    in_a,
    input  logic [FP_W-1:0]    in_b,
    output logic [FP_W-1:0]    div_a,
    output logic [FP_W-1:0]    div_b,
    input  logic [FP_W-1:0]    div_q,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [FP_W-1:0]    out_q,
    output logic [FLAGS_W-1:0] out_flags
);

    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    state_t               r_state;
    state_t               w_state_next;
    logic [CNT_W-1:0]     r_cnt;
    logic [FP_W-1:0]      r_op_a;
    logic [FP_W-1:0]      r_op_b;
    logic [FP_W-1:0]      r_out_q;
    logic [FLAGS_W-1:0]   r_out_flags;
    logic                 r_cooldown;

    logic w_a_zero, w_a_inf, w_a_nan, w_a_norm;
    logic w_b_zero, w_b_inf, w_b_nan, w_b_norm;
    logic w_sign;
    logic w_bypass;
    logic w_accept;
    logic [FP_W-1:0]    w_byp_q;
    logic [FLAGS_W-1:0] w_byp_flags;

    fp_classify u_class_a (
        .op        (in_a),
        .is_zero   (w_a_zero),
        .is_inf    (w_a_inf),
        .is_nan    (w_a_nan),
        .is_normal (w_a_norm)
    );

    fp_classify u_class_b (
        .op        (in_b),
        .is_zero   (w_b_zero),
        .is_inf    (w_b_inf),
        .is_nan    (w_b_nan),
        .is_normal (w_b_norm)
    );

    assign w_sign   = in_a[FP_W-1] ^ in_b[FP_W-1];
    assign w_bypass = !(w_a_norm && w_b_norm);

    // Special-operand result; branch order resolves overlaps such as inf/0 and 0/0.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned, which would infer a latch.
        w_byp_q                   = {w_sign, {(FP_W-1){1'b0}}};
        w_byp_flags               = '0;
        w_byp_flags[FLAG_BYPASS]  = 1'b1;
        if (w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
            w_byp_q                   = QNAN;
            w_byp_flags[FLAG_INVALID] = 1'b1;
        end else if (w_a_inf) begin
            w_byp_q = {w_sign, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
        end else if (w_b_zero) begin
            w_byp_q                = {w_sign, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
            w_byp_flags[FLAG_DIVZ] = 1'b1;
        end
    end

    // The first IDLE cycle after HOLD is a turnaround cycle, giving the SETTLE_CYCLES+3 issue interval.
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = !r_cooldown;
                w_accept = in_valid && !r_cooldown;
                if (w_accept) begin
                    w_state_next = w_bypass ? ST_HOLD : ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (r_cnt == '0) begin
                    w_state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_out_q     <= '0;
            r_out_flags <= '0;
            r_cooldown  <= 1'b0;
        end else begin
            r_cooldown <= (r_state == ST_HOLD) && out_ready;
            if (w_accept) begin
                r_op_a <= in_a;
                r_op_b <= in_b;
                if (w_bypass) begin
                    r_out_q     <= w_byp_q;
                    r_out_flags <= w_byp_flags;
                end else begin
                    r_cnt <= SETTLE_LOAD;
                end
            end else if (r_state == ST_SETTLE) begin
                if (r_cnt == '0) begin
                    r_out_q     <= div_q;
                    r_out_flags <= '0;
                end else begin
                    r_cnt <= r_cnt - 1'b1;
                end
            end
        end
    end

    assign div_a     = r_op_a;
    assign div_b     = r_op_b;
    assign out_q     = r_out_q;
    assign out_flags = r_out_flags;
    assign out_valid = (r_state == ST_HOLD);

endmodule
